// File: rtl/axil_master_arbiter_if.sv
// AXI4-Lite bus bundle between axil_master_arbiter (master modport) and a register slave (slave modport).
interface axil_master_arbiter_if #(
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
    logic                  M_AXI_AWVALID;
    logic                  M_AXI_AWREADY;
    logic [31:0]           M_AXI_WDATA;
    logic [3:0]            M_AXI_WSTRB;
    logic                  M_AXI_WVALID;
    logic                  M_AXI_WREADY;
    logic [1:0]            M_AXI_BRESP;
    logic                  M_AXI_BVALID;
    logic                  M_AXI_BREADY;
    logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic                  M_AXI_ARVALID;
    logic                  M_AXI_ARREADY;
    logic [31:0]           M_AXI_RDATA;
    logic [1:0]            M_AXI_RRESP;
    logic                  M_AXI_RVALID;
    logic                  M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWVALID, input M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARVALID, input M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWVALID, output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARVALID, output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
    );
endinterface

// File: rtl/axil_master_arbiter.sv
// Two-requester arbiter driving a single AXI4-Lite master port, one transaction in flight.
// Define AXIL_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module axil_master_arbiter #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [1:0]              REQ_VALID,
    input  logic [1:0]              REQ_WE,
    input  logic [2*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [63:0]             REQ_WDATA,
    input  logic [7:0]              REQ_WSTRB,
    output logic [1:0]              REQ_ACK,
    output logic [31:0]             REQ_RDATA,
    output logic [1:0]              REQ_RESP,
    axil_master_arbiter_if.master   m_axi
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_WRESP,
        ST_RDATA,
        ST_DONE
    } state_e;

    state_e                state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  bready_q, bready_d;
    logic                  rready_q, rready_d;
    logic [1:0]            ack_q, ack_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            resp_q, resp_d;
    logic                  grant_sel;
    logic                  aw_done;
    logic                  w_done;
`ifndef AXIL_ARB_FIXED_PRIO_EN
    logic                  last_q, last_d;
`endif

    // Requester selection: a lone requester always wins, a tie goes to whoever was not served last.
    always_comb begin
        grant_sel = 1'b0;
`ifdef AXIL_ARB_FIXED_PRIO_EN
        grant_sel = ~REQ_VALID[0];
`else
        if (&REQ_VALID) begin
            grant_sel = ~last_q;
        end else begin
            grant_sel = REQ_VALID[1];
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        bready_d  = bready_q;
        rready_d  = rready_q;
        ack_d     = 2'b00;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        aw_done   = ~awvalid_q | m_axi.M_AXI_AWREADY;
        w_done    = ~wvalid_q | m_axi.M_AXI_WREADY;
`ifndef AXIL_ARB_FIXED_PRIO_EN
        last_d    = last_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (|REQ_VALID) begin
                    gnt_d   = grant_sel;
                    addr_d  = grant_sel ? REQ_ADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : REQ_ADDR[ADDR_WIDTH-1:0];
                    wdata_d = grant_sel ? REQ_WDATA[63:32] : REQ_WDATA[31:0];
                    wstrb_d = grant_sel ? REQ_WSTRB[7:4] : REQ_WSTRB[3:0];
`ifndef AXIL_ARB_FIXED_PRIO_EN
                    last_d  = grant_sel;
`endif
                    if (REQ_WE[grant_sel]) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WRITE;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_READ;
                    end
                end
            end
            // AW and W channels complete independently; leave once both have handshaken.
            ST_WRITE: begin
                if (awvalid_q && m_axi.M_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && m_axi.M_AXI_WREADY) begin
                    wvalid_d = 1'b0;
                end
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (m_axi.M_AXI_BVALID) begin
                    resp_d   = m_axi.M_AXI_BRESP;
                    bready_d = 1'b0;
                    ack_d    = gnt_q ? 2'b10 : 2'b01;
                    state_d  = ST_DONE;
                end
            end
            ST_READ: begin
                if (m_axi.M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (m_axi.M_AXI_RVALID) begin
                    rdata_d  = m_axi.M_AXI_RDATA;
                    resp_d   = m_axi.M_AXI_RRESP;
                    rready_d = 1'b0;
                    ack_d    = gnt_q ? 2'b10 : 2'b01;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= 2'b00;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
`ifndef AXIL_ARB_FIXED_PRIO_EN
            last_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
`ifndef AXIL_ARB_FIXED_PRIO_EN
            last_q    <= last_d;
`endif
        end
    end

    assign REQ_ACK             = ack_q;
    assign REQ_RDATA           = rdata_q;
    assign REQ_RESP            = resp_q;
    assign m_axi.M_AXI_AWADDR  = addr_q;
    assign m_axi.M_AXI_AWVALID = awvalid_q;
    assign m_axi.M_AXI_WDATA   = wdata_q;
    assign m_axi.M_AXI_WSTRB   = wstrb_q;
    assign m_axi.M_AXI_WVALID  = wvalid_q;
    assign m_axi.M_AXI_BREADY  = bready_q;
    assign m_axi.M_AXI_ARADDR  = addr_q;
    assign m_axi.M_AXI_ARVALID = arvalid_q;
    assign m_axi.M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Scoreboard bench for axil_master_arbiter: directed requester traffic against a small AXI4-Lite register slave model.
module tb_axil_master_arbiter;

    typedef struct {
        int          id;
        bit          rd;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [1:0]  REQ_ACK;
    logic [31:0] REQ_RDATA;
    logic [1:0]  REQ_RESP;

    logic        rv  [2] = '{1'b0, 1'b0};
    logic        rwe [2] = '{1'b0, 1'b0};
    logic [3:0]  ra  [2] = '{4'h0, 4'h0};
    logic [31:0] rwd [2] = '{32'h0, 32'h0};
    logic [3:0]  rws [2] = '{4'h0, 4'h0};

    int check_count = 0;
    int pass_count  = 0;
    exp_t sb[$];

    int aw_stall = 0;
    int w_stall  = 0;
    int ar_stall = 0;
    logic [1:0] slv_bresp = 2'b00;
    logic [1:0] slv_rresp = 2'b00;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    bit aw_got = 0, w_got = 0;
    logic [3:0]  slv_addr = 4'h0;
    logic [31:0] slv_wdata = 32'h0;
    logic [3:0]  slv_wstrb = 4'h0;
    logic [31:0] mem [4] = '{32'h0, 32'h0, 32'h0, 32'h0};

    int aw_cyc = 0, w_cyc = 0, aw_hs = 0, b_hs = 0;

    axil_master_arbiter_if #(.ADDR_WIDTH(4)) bus ();

    axil_master_arbiter #(.ADDR_WIDTH(4)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .REQ_VALID ({rv[1], rv[0]}),
        .REQ_WE    ({rwe[1], rwe[0]}),
        .REQ_ADDR  ({ra[1], ra[0]}),
        .REQ_WDATA ({rwd[1], rwd[0]}),
        .REQ_WSTRB ({rws[1], rws[0]}),
        .REQ_ACK   (REQ_ACK),
        .REQ_RDATA (REQ_RDATA),
        .REQ_RESP  (REQ_RESP),
        .m_axi     (bus)
    );

    always #5 ACLK = ~ACLK;

    // Slave readies rise after a programmable number of stalled VALID cycles (0 = ready immediately).
    assign bus.M_AXI_AWREADY = (aw_cnt >= aw_stall);
    assign bus.M_AXI_WREADY  = (w_cnt >= w_stall);
    assign bus.M_AXI_ARREADY = (ar_cnt >= ar_stall);

    always @(posedge ACLK) begin
        if (ARESET) begin
            aw_cnt <= 0;
            w_cnt <= 0;
            ar_cnt <= 0;
            aw_got <= 0;
            w_got <= 0;
            bus.M_AXI_BVALID <= 1'b0;
            bus.M_AXI_BRESP <= 2'b00;
            bus.M_AXI_RVALID <= 1'b0;
            bus.M_AXI_RRESP <= 2'b00;
            bus.M_AXI_RDATA <= 32'h0;
        end else begin
            aw_cnt <= (bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (bus.M_AXI_WVALID && !bus.M_AXI_WREADY) ? w_cnt + 1 : 0;
            ar_cnt <= (bus.M_AXI_ARVALID && !bus.M_AXI_ARREADY) ? ar_cnt + 1 : 0;
            if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
                aw_got <= 1;
                slv_addr <= bus.M_AXI_AWADDR;
            end
            if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
                w_got <= 1;
                slv_wdata <= bus.M_AXI_WDATA;
                slv_wstrb <= bus.M_AXI_WSTRB;
            end
            if (aw_got && w_got) begin
                for (int b = 0; b < 4; b++) begin
                    if (slv_wstrb[b]) mem[slv_addr[3:2]][b*8 +: 8] <= slv_wdata[b*8 +: 8];
                end
                aw_got <= 0;
                w_got <= 0;
                bus.M_AXI_BVALID <= 1'b1;
                bus.M_AXI_BRESP <= slv_bresp;
            end
            if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) bus.M_AXI_BVALID <= 1'b0;
            if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
                bus.M_AXI_RVALID <= 1'b1;
                bus.M_AXI_RDATA <= mem[bus.M_AXI_ARADDR[3:2]];
                bus.M_AXI_RRESP <= slv_rresp;
            end
            if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) bus.M_AXI_RVALID <= 1'b0;
        end
    end

    // Every ACK cycle consumes exactly one expected completion, in grant order.
    always @(negedge ACLK) begin
        exp_t e;
        logic [1:0] exp_ack;
        if (!ARESET) begin
            if (bus.M_AXI_AWVALID) aw_cyc++;
            if (bus.M_AXI_WVALID) w_cyc++;
            if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) aw_hs++;
            if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) b_hs++;
            if (REQ_ACK != 2'b00) begin
                check_count++;
                if (sb.size() == 0) begin
                    $display("[TB] FAIL unexpected_ack: got ack=%b, required no ack", REQ_ACK);
                end else begin
                    e = sb.pop_front();
                    exp_ack = (e.id == 1) ? 2'b10 : 2'b01;
                    if (REQ_ACK === exp_ack && REQ_RESP === e.resp && (!e.rd || REQ_RDATA === e.rdata)) begin
                        pass_count++;
                    end else begin
                        $display("[TB] FAIL ack_compare: got ack=%b resp=%b rdata=%h, required ack=%b resp=%b rdata=%h%s",
                                 REQ_ACK, REQ_RESP, REQ_RDATA, exp_ack, e.resp, e.rdata, e.rd ? "" : " (rdata unchecked)");
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        check_count++;
        if (act === req) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expectAck(input int id, input bit rd, input logic [31:0] rdata, input logic [1:0] resp);
        exp_t e;
        e.id = id;
        e.rd = rd;
        e.rdata = rdata;
        e.resp = resp;
        sb.push_back(e);
    endtask

    // mode 0: drop valid after ACK; 1: keep valid for a follow-on command; 2: drop valid right after grant.
    task automatic applyStimulus(input int i, input bit we, input logic [3:0] addr,
                                 input logic [31:0] wd, input logic [3:0] st, input int mode);
        bit got;
        rv[i] = 1'b1;
        rwe[i] = we;
        ra[i] = addr;
        rwd[i] = wd;
        rws[i] = st;
        if (mode == 2) begin
            @(posedge ACLK);
            #1;
            rv[i] = 1'b0;
        end
        got = 0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge ACLK);
            if (REQ_ACK[i]) got = 1;
        end
        if (!got) begin
            check_count++;
            $display("[TB] FAIL ack_timeout: requester %0d got no ack, required ack within 60 cycles", i);
        end
        @(posedge ACLK);
        #1;
        if (mode != 1) rv[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        bit seen;
        int aw0, w0, awh0, bh0;

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        checkOutput("rst_ack", 32'(REQ_ACK), 32'h0);
        checkOutput("rst_rdata", REQ_RDATA, 32'h0);
        checkOutput("rst_resp", 32'(REQ_RESP), 32'h0);
        checkOutput("rst_valid_ready", 32'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                                            bus.M_AXI_BREADY, bus.M_AXI_RREADY}), 32'h0);
        checkOutput("rst_addr_data", {bus.M_AXI_AWADDR, bus.M_AXI_WDATA[27:0]}, 32'h0);
        ARESET = 1'b0;
        @(posedge ACLK);
        #1;

        expectAck(0, 0, 32'h0, 2'b00);
        applyStimulus(0, 1, 4'h0, 32'h1234CAFE, 4'b0011, 0);
        expectAck(1, 1, 32'h0000CAFE, 2'b00);
        applyStimulus(1, 0, 4'h0, 32'h0, 4'h0, 0);

        expectAck(0, 0, 32'h0, 2'b00);
        expectAck(1, 1, 32'hFACEB00C, 2'b00);
        fork
            applyStimulus(0, 1, 4'h4, 32'hFACEB00C, 4'hF, 0);
            applyStimulus(1, 0, 4'h4, 32'h0, 4'h0, 0);
        join

        for (int k = 0; k < 4; k++) begin
            expectAck(0, 0, 32'h0, 2'b00);
            expectAck(1, 1, 32'hFACEB00C, 2'b00);
        end
        fork
            begin
                for (int k = 0; k < 4; k++) applyStimulus(0, 1, 4'h8, 32'h11110000 + 32'(k), 4'hF, 1);
                rv[0] = 1'b0;
            end
            begin
                for (int k = 0; k < 4; k++) applyStimulus(1, 0, 4'h4, 32'h0, 4'h0, 1);
                rv[1] = 1'b0;
            end
        join
        expectAck(1, 1, 32'h11110003, 2'b00);
        applyStimulus(1, 0, 4'h8, 32'h0, 4'h0, 0);

        aw_stall = 3;
        aw0 = aw_cyc; w0 = w_cyc; awh0 = aw_hs; bh0 = b_hs;
        expectAck(0, 0, 32'h0, 2'b00);
        applyStimulus(0, 1, 4'hC, 32'hDEADBEEF, 4'hF, 0);
        checkOutput("stall_awvalid_cycles", 32'(aw_cyc - aw0), 32'd4);
        checkOutput("stall_wvalid_cycles", 32'(w_cyc - w0), 32'd1);
        checkOutput("stall_aw_handshakes", 32'(aw_hs - awh0), 32'd1);
        checkOutput("stall_b_handshakes", 32'(b_hs - bh0), 32'd1);
        aw_stall = 0;
        expectAck(1, 1, 32'hDEADBEEF, 2'b00);
        applyStimulus(1, 0, 4'hC, 32'h0, 4'h0, 0);

        slv_bresp = 2'b10;
        slv_rresp = 2'b11;
        expectAck(0, 0, 32'h0, 2'b10);
        applyStimulus(0, 1, 4'h0, 32'h0BADF00D, 4'hF, 0);
        expectAck(0, 1, 32'h0BADF00D, 2'b11);
        applyStimulus(0, 0, 4'h0, 32'h0, 4'h0, 0);
        slv_bresp = 2'b00;
        slv_rresp = 2'b00;

        rv[0] = 1'b1; rwe[0] = 1'b1; ra[0] = 4'h8; rwd[0] = 32'h55555555; rws[0] = 4'hF;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge ACLK);
            if (bus.M_AXI_BREADY) seen = 1;
        end
        checkOutput("wresp_reached", 32'(seen), 32'h1);
        ARESET = 1'b1;
        rv[0] = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        checkOutput("midrst_valid_ready", 32'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                                               bus.M_AXI_BREADY, bus.M_AXI_RREADY}), 32'h0);
        checkOutput("midrst_ack", 32'(REQ_ACK), 32'h0);
        checkOutput("midrst_rdata", REQ_RDATA, 32'h0);
        ARESET = 1'b0;

        expectAck(0, 1, 32'h0BADF00D, 2'b00);
        expectAck(1, 1, 32'hFACEB00C, 2'b00);
        fork
            applyStimulus(0, 0, 4'h0, 32'h0, 4'h0, 0);
            applyStimulus(1, 0, 4'h4, 32'h0, 4'h0, 0);
        join

        expectAck(0, 0, 32'h0, 2'b00);
        applyStimulus(0, 1, 4'hC, 32'h12345678, 4'hF, 2);
        expectAck(1, 1, 32'h12345678, 2'b00);
        applyStimulus(1, 0, 4'hC, 32'h0, 4'h0, 0);

        repeat (5) @(negedge ACLK);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
